// File: rtl/nfc_sync_fifo.sv
// Single-clock FIFO buffering page/spare bytes between host interface and flash sequencer.
// Latency: write visible on flags next cycle; read data next cycle (standard) or combinational (FWFT).
// Backpressure: writes while FULL and reads while EMPTY are dropped and flagged by OVERFLOW/UNDERFLOW.
module nfc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024,
    parameter int AFVAL = 1020,
    parameter int AEVAL = 4,
    parameter int FWFT  = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     WE,
    input  logic [WIDTH-1:0]         DATA,
    input  logic                     RE,
    output logic [WIDTH-1:0]         Q,
    output logic                     DVLD,
    output logic                     EMPTY,
    output logic                     FULL,
    output logic                     AEMPTY,
    output logic                     AFULL,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     OVERFLOW,
    output logic                     UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AFVAL);
    localparam logic [CW-1:0] CNT_AE   = CW'(AEVAL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             empty_q;
    logic             full_q;
    logic             aempty_q;
    logic             afull_q;
    logic             ovf_q;
    logic             udf_q;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the flags registered at the start of the cycle, so a
    // same-cycle read never frees room for a write (and vice versa).
    always_comb begin
        wr_acc  = WE && !full_q;
        rd_acc  = RE && !empty_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and flags; flags are decoded from the next count so
    // they come straight out of flops with no glitches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wp       <= '0;
            rp       <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wp <= wp + AW'(1);
            if (rd_acc) rp <= rp + AW'(1);
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == CNT_FULL);
            afull_q  <= (count_d >= CNT_AF);
            aempty_q <= (count_d <= CNT_AE);
            ovf_q    <= WE && full_q;
            udf_q    <= RE && empty_q;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RESET) mem[wp] <= DATA;
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [WIDTH-1:0] q_r;
            logic             dvld_r;

            // Registered read port: Q updates only on an accepted read and
            // holds otherwise; DVLD marks the cycle following acceptance.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    q_r    <= '0;
                    dvld_r <= 1'b0;
                end else begin
                    dvld_r <= rd_acc;
                    if (rd_acc) q_r <= mem[rp];
                end
            end

            assign Q    = q_r;
            assign DVLD = dvld_r;
        end else begin : g_fwft
            // Head word is presented directly; zero while empty so Q reads as
            // 0x00 after reset.
            assign DVLD = !empty_q;
            assign Q    = empty_q ? '0 : mem[rp];
        end
    endgenerate

    assign EMPTY     = empty_q;
    assign FULL      = full_q;
    assign AEMPTY    = aempty_q;
    assign AFULL     = afull_q;
    assign COUNT     = count_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = udf_q;

endmodule

// File: tb/tb_nfc_sync_fifo.sv
// Self-checking bench for nfc_sync_fifo: standard and FWFT builds driven in parallel.
// Reference model is a byte queue updated once per clock from the acceptance rules.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_nfc_sync_fifo;

    localparam int W   = 8;
    localparam int D   = 16;
    localparam int AF  = 14;
    localparam int AE  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         we  = 1'b0;
    logic         re  = 1'b0;
    logic [W-1:0] din = '0;

    logic [W-1:0] q0, q1;
    logic         dvld0, empty0, full0, aempty0, afull0, ovf0, udf0;
    logic         dvld1, empty1, full1, aempty1, afull1, ovf1, udf1;
    logic [4:0]   count0, count1;

    // reference model state
    logic [7:0]   mq[$];
    logic [7:0]   exp_q    = '0;
    logic         exp_dvld = 1'b0;
    logic         exp_ovf  = 1'b0;
    logic         exp_udf  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nfc_sync_fifo #(.WIDTH(W), .DEPTH(D), .AFVAL(AF), .AEVAL(AE), .FWFT(0)) dut_std (
        .CLK(clk), .RESET(rst), .WE(we), .DATA(din), .RE(re),
        .Q(q0), .DVLD(dvld0), .EMPTY(empty0), .FULL(full0), .AEMPTY(aempty0),
        .AFULL(afull0), .COUNT(count0), .OVERFLOW(ovf0), .UNDERFLOW(udf0)
    );

    nfc_sync_fifo #(.WIDTH(W), .DEPTH(D), .AFVAL(AF), .AEVAL(AE), .FWFT(1)) dut_fwft (
        .CLK(clk), .RESET(rst), .WE(we), .DATA(din), .RE(re),
        .Q(q1), .DVLD(dvld1), .EMPTY(empty1), .FULL(full1), .AEMPTY(aempty1),
        .AFULL(afull1), .COUNT(count1), .OVERFLOW(ovf1), .UNDERFLOW(udf1)
    );

    // One clock of stimulus plus the matching model update.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rs);
        int sz;
        @(negedge clk);
        we = w; re = r; din = d; rst = rs;
        @(posedge clk);
        sz = mq.size();
        if (rs) begin
            mq.delete();
            exp_q = '0; exp_dvld = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
        end else begin
            exp_ovf  = w && (sz == D);
            exp_udf  = r && (sz == 0);
            exp_dvld = 1'b0;
            if (r && sz > 0) begin
                exp_q    = mq.pop_front();
                exp_dvld = 1'b1;
            end
            if (w && sz < D) mq.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        n_vec++; if (count0 !== 5'd0)  begin n_err++; $display("FAIL reset_count got %0d want 0", count0); end
        n_vec++; if (empty0 !== 1'b1)  begin n_err++; $display("FAIL reset_empty got %b want 1", empty0); end
        n_vec++; if (aempty0 !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", aempty0); end
        n_vec++; if (full0 !== 1'b0)   begin n_err++; $display("FAIL reset_full got %b want 0", full0); end
        n_vec++; if (afull0 !== 1'b0)  begin n_err++; $display("FAIL reset_afull got %b want 0", afull0); end
        n_vec++; if (dvld0 !== 1'b0)   begin n_err++; $display("FAIL reset_dvld got %b want 0", dvld0); end
        n_vec++; if (q0 !== 8'h00)     begin n_err++; $display("FAIL reset_q got %h want 00", q0); end
        n_vec++; if ({ovf0, udf0} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b want 00", {ovf0, udf0}); end
        n_vec++; if (dvld1 !== 1'b0)   begin n_err++; $display("FAIL reset_fwft_dvld got %b want 0", dvld1); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < D; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            n_vec++; if (count0 !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count got %0d want %0d", count0, i + 1); end
            n_vec++; if (empty0 !== 1'b0) begin n_err++; $display("FAIL fill_empty got %b want 0", empty0); end
            n_vec++; if (aempty0 !== (i + 1 <= AE)) begin n_err++; $display("FAIL fill_aempty got %b at count %0d", aempty0, i + 1); end
            n_vec++; if (afull0 !== (i + 1 >= AF)) begin n_err++; $display("FAIL fill_afull got %b at count %0d", afull0, i + 1); end
            n_vec++; if (full0 !== (i + 1 == D)) begin n_err++; $display("FAIL fill_full got %b at count %0d", full0, i + 1); end
        end
    endtask

    task automatic test_overflow_drain;
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        n_vec++; if (ovf0 !== 1'b1)    begin n_err++; $display("FAIL ovf_pulse got %b want 1", ovf0); end
        n_vec++; if (count0 !== 5'd16) begin n_err++; $display("FAIL ovf_count got %0d want 16", count0); end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        n_vec++; if (ovf0 !== 1'b0)    begin n_err++; $display("FAIL ovf_clear got %b want 0", ovf0); end
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_vec++; if (dvld0 !== 1'b1) begin n_err++; $display("FAIL drain_dvld got %b want 1", dvld0); end
            n_vec++; if (q0 !== 8'(i)) begin n_err++; $display("FAIL drain_q got %h want %h", q0, 8'(i)); end
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        n_vec++; if (dvld0 !== 1'b0) begin n_err++; $display("FAIL drain_dvld_idle got %b want 0", dvld0); end
        n_vec++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty0); end
    endtask

    task automatic test_underflow;
        logic [7:0] held;
        held = q0;
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (udf0 !== 1'b1)  begin n_err++; $display("FAIL udf_pulse got %b want 1", udf0); end
        n_vec++; if (q0 !== held)    begin n_err++; $display("FAIL udf_q_hold got %h want %h", q0, held); end
        n_vec++; if (dvld0 !== 1'b0) begin n_err++; $display("FAIL udf_dvld got %b want 0", dvld0); end
        step(1'b1, 1'b1, 8'h55, 1'b0);
        n_vec++; if (count0 !== 5'd1) begin n_err++; $display("FAIL wr_rd_empty_count got %0d want 1", count0); end
        n_vec++; if (udf0 !== 1'b1)   begin n_err++; $display("FAIL wr_rd_empty_udf got %b want 1", udf0); end
        n_vec++; if (dvld0 !== 1'b0)  begin n_err++; $display("FAIL wr_rd_empty_dvld got %b want 0", dvld0); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (q0 !== 8'h55)    begin n_err++; $display("FAIL udf_followup_q got %h want 55", q0); end
        n_vec++; if (udf0 !== 1'b0)   begin n_err++; $display("FAIL udf_followup_udf got %b want 0", udf0); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
            n_vec++; if (count0 !== 5'd8) begin n_err++; $display("FAIL b2b_count got %0d want 8", count0); end
            n_vec++; if (dvld0 !== 1'b1)  begin n_err++; $display("FAIL b2b_dvld got %b want 1", dvld0); end
            n_vec++; if (q0 !== exp_q)    begin n_err++; $display("FAIL b2b_q got %h want %h", q0, exp_q); end
            n_vec++; if (q1 !== mq[0])    begin n_err++; $display("FAIL b2b_fwft_q got %h want %h", q1, mq[0]); end
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            n_vec++; if (q0 !== exp_q) begin n_err++; $display("FAIL b2b_tail_q got %h want %h", q0, exp_q); end
        end
    endtask

    task automatic test_fwft;
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        n_vec++; if (empty1 !== 1'b0) begin n_err++; $display("FAIL fwft_empty got %b want 0", empty1); end
        n_vec++; if (dvld1 !== 1'b1)  begin n_err++; $display("FAIL fwft_dvld got %b want 1", dvld1); end
        n_vec++; if (q1 !== 8'h3C)    begin n_err++; $display("FAIL fwft_q got %h want 3c", q1); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (empty1 !== 1'b1) begin n_err++; $display("FAIL fwft_empty_after got %b want 1", empty1); end
        n_vec++; if (dvld1 !== 1'b0)  begin n_err++; $display("FAIL fwft_dvld_after got %b want 0", dvld1); end
        n_vec++; if (q0 !== 8'h3C)    begin n_err++; $display("FAIL fwft_std_q got %h want 3c", q0); end
    endtask

    task automatic test_reset_midburst;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        n_vec++; if (count0 !== 5'd10) begin n_err++; $display("FAIL mid_pre_count got %0d want 10", count0); end
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        n_vec++; if (count0 !== 5'd0)  begin n_err++; $display("FAIL mid_count got %0d want 0", count0); end
        n_vec++; if (empty0 !== 1'b1)  begin n_err++; $display("FAIL mid_empty got %b want 1", empty0); end
        n_vec++; if (aempty0 !== 1'b1) begin n_err++; $display("FAIL mid_aempty got %b want 1", aempty0); end
        n_vec++; if (q0 !== 8'h00)     begin n_err++; $display("FAIL mid_q got %h want 00", q0); end
        n_vec++; if (dvld0 !== 1'b0)   begin n_err++; $display("FAIL mid_dvld got %b want 0", dvld0); end
        n_vec++; if (count1 !== 5'd0)  begin n_err++; $display("FAIL mid_fwft_count got %0d want 0", count1); end
        n_vec++; if (dvld1 !== 1'b0)   begin n_err++; $display("FAIL mid_fwft_dvld got %b want 0", dvld1); end
        step(1'b1, 1'b0, 8'h77, 1'b0);
        n_vec++; if (q1 !== 8'h77)     begin n_err++; $display("FAIL mid_fwft_q got %h want 77", q1); end
        step(1'b0, 1'b1, 8'h00, 1'b0);
        n_vec++; if (q0 !== 8'h77)     begin n_err++; $display("FAIL mid_q_after got %h want 77", q0); end
        n_vec++; if (dvld0 !== 1'b1)   begin n_err++; $display("FAIL mid_dvld_after got %b want 1", dvld0); end
    endtask

    task automatic test_random;
        int sz;
        logic w, r;
        for (int i = 0; i < 600; i++) begin
            // bias toward filling in the first half, draining in the second
            w = ($urandom_range(0, 99) < ((i < 300) ? 65 : 35));
            r = ($urandom_range(0, 99) < ((i < 300) ? 35 : 65));
            step(w, r, 8'($urandom), 1'b0);
            sz = mq.size();
            n_vec++; if (count0 !== 5'(sz))        begin n_err++; $display("FAIL rnd_count got %0d want %0d", count0, sz); end
            n_vec++; if (count1 !== 5'(sz))        begin n_err++; $display("FAIL rnd_fwft_count got %0d want %0d", count1, sz); end
            n_vec++; if (empty0 !== (sz == 0))     begin n_err++; $display("FAIL rnd_empty got %b size %0d", empty0, sz); end
            n_vec++; if (full0 !== (sz == D))      begin n_err++; $display("FAIL rnd_full got %b size %0d", full0, sz); end
            n_vec++; if (afull0 !== (sz >= AF))    begin n_err++; $display("FAIL rnd_afull got %b size %0d", afull0, sz); end
            n_vec++; if (aempty0 !== (sz <= AE))   begin n_err++; $display("FAIL rnd_aempty got %b size %0d", aempty0, sz); end
            n_vec++; if (ovf0 !== exp_ovf)         begin n_err++; $display("FAIL rnd_ovf got %b want %b", ovf0, exp_ovf); end
            n_vec++; if (udf0 !== exp_udf)         begin n_err++; $display("FAIL rnd_udf got %b want %b", udf0, exp_udf); end
            n_vec++; if (dvld0 !== exp_dvld)       begin n_err++; $display("FAIL rnd_dvld got %b want %b", dvld0, exp_dvld); end
            n_vec++; if (q0 !== exp_q)             begin n_err++; $display("FAIL rnd_q got %h want %h", q0, exp_q); end
            n_vec++; if (dvld1 !== (sz != 0))      begin n_err++; $display("FAIL rnd_fwft_dvld got %b size %0d", dvld1, sz); end
            if (sz != 0) begin
                n_vec++; if (q1 !== mq[0])         begin n_err++; $display("FAIL rnd_fwft_q got %h want %h", q1, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_reset_midburst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
